// File: rtl/vertex_transform_stream.sv
// Streams DIM-component Q(M.N) vertices through a double-buffered DIM x DIM matrix multiply.
// Define VERTEX_SATURATE_EN to clamp results to M bits instead of wrapping them.
module vertex_transform_stream #(
  parameter int M   = 11,
  parameter int N   = 7,
  parameter int DIM = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic signed [M+N-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic signed [M-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  input  logic                  cfg_we,
  input  logic [3:0]            cfg_addr,
  input  logic signed [M+N-1:0] cfg_data,
  input  logic                  cfg_commit,
  output logic                  cfg_pending
);
  localparam int W  = M + N;
  localparam int PW = 2 * W;
  localparam int AW = PW + 2;
  localparam logic [1:0] LAST_IDX = 2'(DIM - 1);
  localparam logic [2:0] DIM_W    = 3'(DIM);
  localparam logic signed [W-1:0] ONE = W'(64'd1 << N);

  logic signed [W-1:0]  act_q [DIM][DIM];
  logic signed [W-1:0]  shd_q [DIM][DIM];
  logic [1:0]           in_idx_q;
  logic                 pend_q;
  logic                 cfg_pending_q;
  logic signed [PW-1:0] prod_q [DIM];
  logic                 prod_vld_q;
  logic [1:0]           prod_idx_q;
  logic signed [AW-1:0] acc_q [DIM];
  logic signed [AW-1:0] acc_d [DIM];
  logic                 acc_done_q;
  logic signed [M-1:0]  obuf_q [DIM];
  logic signed [M-1:0]  res_s [DIM];
  logic [1:0]           optr_q;
  logic [1:0]           optr_nxt_s;
  logic                 out_valid_q;
  logic                 out_last_q;
  logic signed [M-1:0]  out_data_q;

  logic out_fire_s, final_fire_s, in_ready_s, in_fire_s, last_fire_s, do_copy_s;
  logic [1:0] cfg_row_s, cfg_col_s;
  logic cfg_hit_s;

  // Scale the accumulator back to an integer and fit it into M bits.
  function automatic logic signed [M-1:0] reduce_acc(input logic signed [AW-1:0] acc);
`ifdef VERTEX_SATURATE_EN
    logic signed [AW-1:0] shifted;
    logic signed [AW-1:0] sat_max;
    sat_max = AW'((64'sd1 <<< (M - 1)) - 64'sd1);
    shifted = acc >>> (2 * N);
    if (shifted > sat_max)       reduce_acc = sat_max[M-1:0];
    else if (shifted < ~sat_max) reduce_acc = {1'b1, {(M-1){1'b0}}};
    else                         reduce_acc = shifted[M-1:0];
`else
    reduce_acc = acc[2*N +: M];
`endif
  endfunction

  assign out_fire_s   = out_valid_q & out_ready;
  assign final_fire_s = out_fire_s & out_last_q;
  // The last beat of the next vertex waits until the previous result has fully drained.
  assign in_ready_s   = !((in_idx_q == LAST_IDX) && pend_q && !final_fire_s);
  assign in_fire_s    = in_valid & in_ready_s & !flush;
  assign last_fire_s  = in_fire_s & (in_idx_q == LAST_IDX);
  // Swap matrices only on a vertex boundary so no vertex sees two matrices.
  assign do_copy_s    = cfg_pending_q & (((in_idx_q == 2'd0) & !in_fire_s) | last_fire_s);
  assign cfg_row_s    = cfg_addr[3:2];
  assign cfg_col_s    = cfg_addr[1:0];
  assign cfg_hit_s    = cfg_we & ({1'b0, cfg_row_s} < DIM_W) & ({1'b0, cfg_col_s} < DIM_W);
  assign optr_nxt_s   = optr_q + 2'd1;

  assign in_ready    = in_ready_s;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign cfg_pending = cfg_pending_q;

  // Accumulator next-state and reduced results.
  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      acc_d[i] = ((prod_idx_q == 2'd0) ? {AW{1'b0}} : acc_q[i]) +
                 {{2{prod_q[i][PW-1]}}, prod_q[i]};
      res_s[i] = reduce_acc(acc_q[i]);
    end
  end

  // Active and shadow matrices; a same-edge write lands only in the shadow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          act_q[r][c] <= (r == c) ? ONE : {W{1'b0}};
          shd_q[r][c] <= (r == c) ? ONE : {W{1'b0}};
        end
      end
    end else begin
      if (do_copy_s) begin
        for (int r = 0; r < DIM; r++) begin
          for (int c = 0; c < DIM; c++) begin
            act_q[r][c] <= shd_q[r][c];
          end
        end
      end
      if (cfg_hit_s) begin
        shd_q[cfg_row_s][cfg_col_s] <= cfg_data;
      end
    end
  end

  // Commit request flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cfg_pending_q <= 1'b0;
    else          cfg_pending_q <= do_copy_s ? 1'b0 : (cfg_pending_q | cfg_commit);
  end

  // Input beat index and result-pending flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_idx_q <= 2'd0;
      pend_q   <= 1'b0;
    end else if (flush) begin
      in_idx_q <= 2'd0;
      pend_q   <= 1'b0;
    end else begin
      if (in_fire_s) in_idx_q <= (in_idx_q == LAST_IDX) ? 2'd0 : in_idx_q + 2'd1;
      if (last_fire_s)       pend_q <= 1'b1;
      else if (final_fire_s) pend_q <= 1'b0;
    end
  end

  // Product stage then accumulate stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_vld_q <= 1'b0;
      prod_idx_q <= 2'd0;
      acc_done_q <= 1'b0;
      for (int i = 0; i < DIM; i++) begin
        prod_q[i] <= {PW{1'b0}};
        acc_q[i]  <= {AW{1'b0}};
      end
    end else if (flush) begin
      prod_vld_q <= 1'b0;
      acc_done_q <= 1'b0;
      for (int i = 0; i < DIM; i++) acc_q[i] <= {AW{1'b0}};
    end else begin
      prod_vld_q <= in_fire_s;
      acc_done_q <= prod_vld_q && (prod_idx_q == LAST_IDX);
      if (in_fire_s) begin
        prod_idx_q <= in_idx_q;
        for (int i = 0; i < DIM; i++) prod_q[i] <= act_q[i][in_idx_q] * in_data;
      end
      if (prod_vld_q) begin
        for (int i = 0; i < DIM; i++) acc_q[i] <= acc_d[i];
      end
    end
  end

  // Output buffer: loads a whole vector, then emits one component per handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= {M{1'b0}};
      optr_q      <= 2'd0;
      for (int i = 0; i < DIM; i++) obuf_q[i] <= {M{1'b0}};
    end else if (flush) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (acc_done_q) begin
      for (int i = 0; i < DIM; i++) obuf_q[i] <= res_s[i];
      out_data_q  <= res_s[0];
      out_valid_q <= 1'b1;
      out_last_q  <= 1'b0;
      optr_q      <= 2'd0;
    end else if (out_fire_s) begin
      if (out_last_q) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else begin
        optr_q     <= optr_nxt_s;
        out_data_q <= obuf_q[optr_nxt_s];
        out_last_q <= (optr_nxt_s == LAST_IDX);
      end
    end
  end

endmodule

// File: tb/tb_vertex_transform_stream.sv
// Directed bench for vertex_transform_stream with a vertex-level reference model.
module tb_vertex_transform_stream;
  logic clk = 1'b0;
  logic reset_n, flush, in_valid, out_ready, cfg_we, cfg_commit;
  logic signed [17:0] in_data, cfg_data;
  logic [3:0] cfg_addr;
  logic in_ready, out_valid, out_last, cfg_pending;
  logic signed [10:0] out_data;

  int checks = 0;
  int failures = 0;
  int mA [4][4];
  int mS [4][4];
  bit cm_pending;
  int exp_q[$];
  bit exp_last_q[$];
  int recv_q[$];

  always #5 clk = ~clk;

  vertex_transform_stream dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_pending(cfg_pending)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mA[r][c] = (r == c) ? 128 : 0;
        mS[r][c] = (r == c) ? 128 : 0;
      end
    cm_pending = 1'b0;
    exp_q.delete();
    exp_last_q.delete();
  endtask

  // Expected outputs: plain matrix product, divide by 2^14, then clamp or wrap to 11 bits.
  task automatic model_vertex(input int v[4]);
    longint acc, s;
    logic signed [10:0] t;
    for (int i = 0; i < 4; i++) begin
      acc = 0;
      for (int j = 0; j < 4; j++) acc += longint'(mA[i][j]) * longint'(v[j]);
      s = acc >>> 14;
`ifdef VERTEX_SATURATE_EN
      if (s > 1023) s = 1023;
      else if (s < -1024) s = -1024;
`endif
      t = s[10:0];
      exp_q.push_back(int'(t));
      exp_last_q.push_back(i == 3);
    end
    if (cm_pending) begin
      mA = mS;
      cm_pending = 1'b0;
    end
  endtask

  task automatic send_beat(input int v);
    bit done = 1'b0;
    int n = 0;
    in_data = v[17:0];
    in_valid = 1'b1;
    while (!done && n < 200) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic send_vertex(input int v[4]);
    for (int j = 0; j < 4; j++) send_beat(v[j]);
    model_vertex(v);
  endtask

  task automatic cfg_write(input int addr, input int val);
    cfg_we = 1'b1;
    cfg_addr = addr[3:0];
    cfg_data = val[17:0];
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    mS[addr / 4][addr % 4] = val;
  endtask

  task automatic commit_pulse();
    cfg_commit = 1'b1;
    @(posedge clk);
    #1;
    cfg_commit = 1'b0;
    cm_pending = 1'b1;
  endtask

  task automatic commit_idle();
    commit_pulse();
    @(negedge clk);
    chk("cfg_pending_set", int'(cfg_pending), 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("cfg_pending_clr", int'(cfg_pending), 0);
    mA = mS;
    cm_pending = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic expect_recv(input string nm, input int e[], input int base);
    for (int k = 0; k < e.size(); k++) begin
      if (base + k < recv_q.size()) chk(nm, recv_q[base + k], e[k]);
      else chk({nm, "_missing"}, recv_q.size(), base + k + 1);
    end
  endtask

  // Scoreboard: every handshake must match the model; stalled outputs must hold.
  initial begin
    bit prev_stall = 1'b0;
    int prev_d = 0;
    int prev_l = 0;
    int e;
    bit el;
    forever begin
      @(negedge clk);
      if (reset_n && prev_stall && out_valid) begin
        chk("hold_data", int'(out_data), prev_d);
        chk("hold_last", int'(out_last), prev_l);
      end
      if (reset_n && !flush && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", int'(out_data), 99999);
        end else begin
          e = exp_q.pop_front();
          el = exp_last_q.pop_front();
          chk("out_data", int'(out_data), e);
          chk("out_last", int'(out_last), int'(el));
          recv_q.push_back(int'(out_data));
        end
      end
      prev_stall = reset_n && out_valid && !out_ready && !flush;
      prev_d = int'(out_data);
      prev_l = int'(out_last);
    end
  end

  initial begin
    int v[4];
    int u[4];
    int e4[];
    int e8[];
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = '0; cfg_commit = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_cfg_pending", int'(cfg_pending), 0);
    @(posedge clk);
    #1;

    // 1: identity, latency of two edges after the last beat
    recv_q.delete();
    v = '{128, 256, 384, 128};
    send_vertex(v);
    @(negedge clk); chk("lat_t0", int'(out_valid), 0);
    @(negedge clk); chk("lat_t1", int'(out_valid), 0);
    @(negedge clk); chk("lat_t2", int'(out_valid), 1);
    @(posedge clk); #1;
    drain();
    e4 = '{1, 2, 3, 1};
    expect_recv("t1_lit", e4, 0);

    // 2: reload matrix with idle commit
    recv_q.delete();
    cfg_write(3, 640);
    cfg_write(7, -384);
    commit_idle();
    send_vertex(v);
    drain();
    e4 = '{6, -1, 3, 1};
    expect_recv("t2_lit", e4, 0);

    // 3: overflow of output range
    recv_q.delete();
    cfg_write(0, 512);
    cfg_write(3, 0);
    commit_idle();
    u = '{65536, 0, 0, 128};
    send_vertex(u);
    drain();
`ifdef VERTEX_SATURATE_EN
    e4 = '{1023, -3, 0, 1};
`else
    e4 = '{0, -3, 0, 1};
`endif
    expect_recv("t3_lit", e4, 0);

    // 4: backpressure across two vertices
    recv_q.delete();
    out_ready = 1'b0;
    send_vertex(v);
    u = '{256, 128, 0, 128};
    for (int j = 0; j < 3; j++) send_beat(u[j]);
    in_data = u[3][17:0];
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_low", int'(in_ready), 0);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    send_beat(u[3]);
    model_vertex(u);
    drain();
    e8 = '{4, -1, 3, 1, 8, -2, 0, 1};
    expect_recv("t4_lit", e8, 0);
    chk("t4_count", recv_q.size(), 8);

    // 5: commit mid-vertex takes effect on the next vertex
    recv_q.delete();
    cfg_write(0, 256);
    cfg_write(7, 0);
    send_beat(v[0]);
    send_beat(v[1]);
    commit_pulse();
    @(negedge clk); chk("t5_pending_mid", int'(cfg_pending), 1);
    @(posedge clk); #1;
    send_beat(v[2]);
    send_beat(v[3]);
    model_vertex(v);
    @(negedge clk); chk("t5_pending_done", int'(cfg_pending), 0);
    @(posedge clk); #1;
    send_vertex(v);
    drain();
    e8 = '{4, -1, 3, 1, 2, 2, 3, 1};
    expect_recv("t5_lit", e8, 0);

    // flush: drop partial vertex, then drop an unsent result
    recv_q.delete();
    send_beat(256);
    send_beat(256);
    flush_pulse();
    u = '{128, 0, 0, 128};
    send_vertex(u);
    drain();
    e4 = '{2, 0, 0, 1};
    expect_recv("fl_partial", e4, 0);
    out_ready = 1'b0;
    u = '{128, 128, 128, 128};
    send_vertex(u);
    begin
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("fl_ov_seen", int'(out_valid), 1);
    end
    @(posedge clk); #1;
    flush_pulse();
    exp_q.delete();
    exp_last_q.delete();
    @(negedge clk);
    chk("fl_out_valid", int'(out_valid), 0);
    chk("fl_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    recv_q.delete();
    u = '{0, 128, 0, 128};
    send_vertex(u);
    drain();
    e4 = '{0, 1, 0, 1};
    expect_recv("fl_after", e4, 0);
    chk("fl_count", recv_q.size(), 4);

    // 6: reset mid-vertex restores identity, no stale beats
    recv_q.delete();
    send_beat(128);
    send_beat(256);
    send_beat(384);
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst2_in_ready", int'(in_ready), 1);
    chk("rst2_out_valid", int'(out_valid), 0);
    chk("rst2_cfg_pending", int'(cfg_pending), 0);
    @(posedge clk); #1;
    u = '{128, 0, 0, 128};
    send_vertex(u);
    drain();
    e4 = '{1, 0, 0, 1};
    expect_recv("t6_lit", e4, 0);
    chk("t6_count", recv_q.size(), 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
